// File: rtl/nbt_sram_pkg.sv
// Shared types, latency constants and burst address helper for the NBT SRAM model.
package nbt_sram_pkg;

    typedef enum logic [1:0] {
        CMD_DESEL = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_e;

    // Slot fields are sized for the widest supported part; callers zero-extend.
    localparam int SLOT_A_W  = 32;
    localparam int SLOT_BE_W = 32;

    // One command in flight: what it is, which word, which lanes (active-low).
    typedef struct packed {
        cmd_e                 cmd;
        logic [SLOT_A_W-1:0]  addr;
        logic [SLOT_BE_W-1:0] be;
    } slot_t;

    localparam int LAT_PIPE = 2;
    localparam int LAT_FLOW = 1;

    // Burst beat address: only the low lbits move, the upper bits stay at a0.
    function automatic logic [SLOT_A_W-1:0] burst_addr(
        input logic [SLOT_A_W-1:0] a0,
        input logic [SLOT_A_W-1:0] k,
        input int                  lbits,
        input logic                interleaved
    );
        logic [SLOT_A_W-1:0] mask;
        logic [SLOT_A_W-1:0] low;
        mask = (SLOT_A_W'(1) << lbits) - SLOT_A_W'(1);
        low  = interleaved ? ((a0 ^ k) & mask) : ((a0 + k) & mask);
        return (a0 & ~mask) | low;
    endfunction

endpackage

// File: rtl/nbt_sram_model_param_burst.sv
// Command decode and burst sequencing: turns the pins seen at an enabled edge
// into the command and word address issued at that edge.
module nbt_burst_gen
    import nbt_sram_pkg::*;
#(
    parameter int A_BITS    = 19,
    parameter int BURST_LEN = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_sel,
    input  logic                i_nw,
    input  logic                i_adv,
    input  logic                i_zz,
    input  logic                i_ilv,
    input  logic [A_BITS-1:0]   i_addr,
    output cmd_e                o_cmd,
    output logic [SLOT_A_W-1:0] o_addr
);
    localparam int                  K_BITS = $clog2(BURST_LEN);
    localparam logic [SLOT_A_W-1:0] K_MASK = SLOT_A_W'(BURST_LEN - 1);

    cmd_e                r_last_cmd;
    logic [SLOT_A_W-1:0] r_base;
    logic [SLOT_A_W-1:0] r_k;
    cmd_e                w_cmd;
    logic [SLOT_A_W-1:0] w_base;
    logic [SLOT_A_W-1:0] w_k;

    // Load latches a fresh base; advance repeats the last command at the next beat.
    always_comb begin
        w_cmd  = CMD_DESEL;
        w_base = r_base;
        w_k    = r_k;
        if (!i_adv) begin
            w_base = SLOT_A_W'(i_addr);
            w_k    = '0;
            if (i_sel && !i_zz) begin
                w_cmd = i_nw ? CMD_READ : CMD_WRITE;
            end
        end else begin
            w_k   = (r_k + SLOT_A_W'(1)) & K_MASK;
            w_cmd = i_zz ? CMD_DESEL : r_last_cmd;
        end
    end

    assign o_cmd  = w_cmd;
    assign o_addr = burst_addr(w_base, w_k, K_BITS, i_ilv);

    // Burst state moves only on enabled edges; reset kills any burst in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_cmd <= CMD_DESEL;
            r_k        <= '0;
        end else if (i_en) begin
            r_last_cmd <= w_cmd;
            r_base     <= w_base;
            r_k        <= w_k;
        end
    end

endmodule

// File: rtl/nbt_sram_model_param.sv
// Cycle-accurate NBT/ZBT synchronous SRAM model: parametrised lanes, lane width
// and depth, split data bus, pipeline/flow-through latency, linear/interleaved bursts.
module nbt_sram_model_param
    import nbt_sram_pkg::*;
#(
    parameter int A_BITS     = 19,
    parameter int DEPTH_BITS = 19,
    parameter int LANES      = 4,
    parameter int LANE_W     = 9,
    parameter int BURST_LEN  = 4
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic [A_BITS-1:0]        A,
    input  logic                     nE1,
    input  logic                     E2,
    input  logic                     nE3,
    input  logic                     nW,
    input  logic [LANES-1:0]         nB,
    input  logic                     pADV,
    input  logic                     nCKE,
    input  logic                     nG,
    input  logic                     ZZ,
    input  logic                     nFT,
    input  logic                     nLBO,
    input  logic [LANES*LANE_W-1:0]  DQ_I,
    output logic [LANES*LANE_W-1:0]  DQ_O,
    output logic                     DQ_OE
);
    localparam int DATA_W = LANES * LANE_W;
    localparam int WORDS  = 2 ** DEPTH_BITS;

    logic                  w_en;
    logic                  w_sel;
    cmd_e                  w_cmd;
    logic [SLOT_A_W-1:0]   w_addr;
    slot_t                 w_new;
    slot_t                 w_act;
    slot_t                 r_slot_p0;
    slot_t                 r_slot_p1;
    logic [1:0]            w_lat;
    logic [DEPTH_BITS-1:0] w_idx;
    logic [DATA_W-1:0]     w_rd;
    logic [DATA_W-1:0]     r_dq;
    logic                  r_vld;
    logic [DATA_W-1:0]     r_mem [WORDS];
    logic                  w_unused;

    assign w_en  = ~nCKE & ~RST;
    assign w_sel = ~nE1 & E2 & ~nE3;

    nbt_burst_gen #(
        .A_BITS    (A_BITS),
        .BURST_LEN (BURST_LEN)
    ) u_burst (
        .i_clk  (CK),
        .i_rst  (RST),
        .i_en   (w_en),
        .i_sel  (w_sel),
        .i_nw   (nW),
        .i_adv  (pADV),
        .i_zz   (ZZ),
        .i_ilv  (nLBO),
        .i_addr (A),
        .o_cmd  (w_cmd),
        .o_addr (w_addr)
    );

    assign w_new = '{cmd: w_cmd, addr: w_addr, be: SLOT_BE_W'(nB)};

    // The slot whose data beat is due now: one edge old in flow-through, two in pipeline.
    assign w_lat = nFT ? 2'(LAT_PIPE) : 2'(LAT_FLOW);
    assign w_act = (w_lat == 2'(LAT_FLOW)) ? r_slot_p0 : r_slot_p1;
    assign w_idx = w_act.addr[DEPTH_BITS-1:0];

    // A read resolves at its data edge, after every older write has committed at
    // its own (earlier) data edge, so the array already holds the newest bytes of
    // any write that was pending when the read was issued; untouched lanes are
    // whatever the array holds, including X for never-written words.
    assign w_rd = r_mem[w_idx];

    // Upper address/byte-enable bits of the slot are beyond this part's size.
    assign w_unused = ^{w_act.addr, w_act.be};

    // ---- issue (p0) -> data beat (p1 in pipeline mode) ----
    // Command pipeline and output register; reset flushes pending accesses.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_slot_p0.cmd <= CMD_DESEL;
            r_slot_p1.cmd <= CMD_DESEL;
            r_vld         <= 1'b0;
            r_dq          <= '0;
        end else if (!nCKE) begin
            r_slot_p0 <= w_new;
            r_slot_p1 <= r_slot_p0;
            r_vld     <= (w_act.cmd == CMD_READ);
            if (w_act.cmd == CMD_READ) begin
                r_dq <= w_rd;
            end
        end
    end

    // Commit the enabled lanes of a write whose data beat arrives this edge.
    always_ff @(posedge CK) begin
        if (w_en && (w_act.cmd == CMD_WRITE)) begin
            for (int l = 0; l < LANES; l++) begin
                if (!w_act.be[l]) begin
                    r_mem[w_idx][l*LANE_W +: LANE_W] <= DQ_I[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign DQ_O  = r_dq;
    assign DQ_OE = r_vld & ~nG & ~ZZ;

endmodule

// File: tb/tb_nbt_sram_model_param.sv
// Directed + randomized bench for nbt_sram_model_param against an event-scheduled
// reference model (commands scheduled at issue edge + latency, memory as a map).
module tb_nbt_sram_model_param;

    localparam int AW = 19;
    localparam int NL = 4;
    localparam int LW = 9;
    localparam int DW = NL * LW;
    localparam int BL = 4;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] A = '0;
    logic          nE1 = 1'b1;
    logic          E2 = 1'b1;
    logic          nE3 = 1'b0;
    logic          nW = 1'b1;
    logic [NL-1:0] nB = '0;
    logic          pADV = 1'b0;
    logic          nCKE = 1'b0;
    logic          nG = 1'b0;
    logic          ZZ = 1'b0;
    logic          nFT = 1'b1;
    logic          nLBO = 1'b0;
    logic [DW-1:0] DQ_I = '0;
    logic [DW-1:0] DQ_O;
    logic          DQ_OE;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] mmem [int];
    int            s_type [int];   // 0 desel, 1 read, 2 write; keyed by data-beat edge
    int            s_addr [int];
    logic [NL-1:0] s_be   [int];
    int            ecnt   = 0;
    int            m_type = 0;
    int            m_a0   = 0;
    int            m_k    = 0;
    logic          m_vld  = 1'b0;
    logic [DW-1:0] m_dq   = '0;

    nbt_sram_model_param dut (
        .CK    (CK),
        .RST   (RST),
        .A     (A),
        .nE1   (nE1),
        .E2    (E2),
        .nE3   (nE3),
        .nW    (nW),
        .nB    (nB),
        .pADV  (pADV),
        .nCKE  (nCKE),
        .nG    (nG),
        .ZZ    (ZZ),
        .nFT   (nFT),
        .nLBO  (nLBO),
        .DQ_I  (DQ_I),
        .DQ_O  (DQ_O),
        .DQ_OE (DQ_OE)
    );

    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, observed time=%0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rnd36();
        return DW'({$urandom(), $urandom()});
    endfunction

    function automatic logic [DW-1:0] dval(input int i);
        return DW'(36'h0C0DE0000 + i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, using the pins as they stand at that edge.
    task automatic model_edge();
        int a;
        if (RST) begin
            s_type.delete();
            s_addr.delete();
            s_be.delete();
            m_type = 0;
            m_k    = 0;
            m_vld  = 1'b0;
            m_dq   = '0;
        end else if (!nCKE) begin
            ecnt++;
            m_vld = 1'b0;
            if (s_type.exists(ecnt)) begin
                a = s_addr[ecnt];
                if (s_type[ecnt] == 2) begin
                    if (!mmem.exists(a)) mmem[a] = 'x;
                    for (int l = 0; l < NL; l++)
                        if (!s_be[ecnt][l]) mmem[a][l*LW +: LW] = DQ_I[l*LW +: LW];
                end else if (s_type[ecnt] == 1) begin
                    m_dq  = mmem.exists(a) ? mmem[a] : 'x;
                    m_vld = 1'b1;
                end
                s_type.delete(ecnt);
            end
            if (!pADV) begin
                m_a0   = int'(A);
                m_k    = 0;
                m_type = (!nE1 && E2 && !nE3 && !ZZ) ? (nW ? 1 : 2) : 0;
            end else begin
                m_k    = (m_k + 1) % BL;
                m_type = ZZ ? 0 : m_type;
            end
            if (m_type != 0) begin
                a = nLBO ? (m_a0 ^ m_k) : ((m_a0 / BL) * BL + (m_a0 % BL + m_k) % BL);
                s_type[ecnt + (nFT ? 2 : 1)] = m_type;
                s_addr[ecnt + (nFT ? 2 : 1)] = a;
                s_be[ecnt + (nFT ? 2 : 1)]   = nB;
            end
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        model_edge();
        #1;
        chk("dq_oe_model", 64'(DQ_OE), 64'(m_vld & ~nG & ~ZZ));
        chk("dq_o_model", 64'(DQ_O), 64'(m_dq));
    endtask

    task automatic cmd_rd(input int a);
        pADV = 1'b0; nE1 = 1'b0; nW = 1'b1; nB = '0; A = AW'(a); cyc();
    endtask

    task automatic cmd_wr(input int a, input logic [NL-1:0] be);
        pADV = 1'b0; nE1 = 1'b0; nW = 1'b0; nB = be; A = AW'(a); cyc();
    endtask

    task automatic cmd_adv();
        pADV = 1'b1; cyc();
    endtask

    task automatic cmd_nop();
        pADV = 1'b0; nE1 = 1'b1; cyc();
    endtask

    task automatic cmd_hold();
        nCKE = 1'b1; cyc(); nCKE = 1'b0;
    endtask

    task automatic do_reset(input logic ft, input logic lbo);
        RST = 1'b1; nFT = ft; nLBO = lbo; pADV = 1'b0; nE1 = 1'b1;
        cyc(); cyc();
        RST = 1'b0;
    endtask

    int ord_lin [4] = '{2, 3, 0, 1};
    int ord_i2  [4] = '{2, 3, 0, 1};
    int ord_i1  [4] = '{1, 0, 3, 2};

    initial begin
        // Reset state, pipeline mode, linear bursts
        do_reset(1'b1, 1'b0);
        chk("rst_dq_oe", 64'(DQ_OE), 64'd0);
        chk("rst_dq_o", 64'(DQ_O), 64'd0);

        // Preload words 0..16 with random data (back-to-back writes)
        for (int a = 0; a <= 16; a++) begin
            DQ_I = rnd36();
            cmd_wr(a, '0);
        end
        DQ_I = rnd36(); cmd_nop();
        DQ_I = rnd36(); cmd_nop();

        // Pipeline write then read of 0x10
        DQ_I = rnd36(); cmd_wr(16, '0);
        cmd_nop();
        DQ_I = 36'h123456789; cmd_nop();
        DQ_I = rnd36(); cmd_rd(16);
        cmd_nop();
        chk("pipe_oe_early", 64'(DQ_OE), 64'd0);
        cmd_nop();
        chk("pipe_rd_data", 64'(DQ_O), 64'h123456789);
        chk("pipe_rd_oe", 64'(DQ_OE), 64'd1);
        cmd_nop();
        chk("pipe_oe_one_cycle", 64'(DQ_OE), 64'd0);
        chk("pipe_dq_hold", 64'(DQ_O), 64'h123456789);

        // Byte write: lanes 0 and 2 (bits 8:0 and 26:18) cleared
        DQ_I = rnd36(); cmd_wr(5, 4'b0000);
        cmd_nop();
        DQ_I = 36'hFFFFFFFFF; cmd_wr(5, 4'b1010);
        DQ_I = rnd36(); cmd_nop();
        DQ_I = 36'h000000000; cmd_rd(5);
        DQ_I = rnd36(); cmd_nop();
        cmd_nop();
        chk("byte_write", 64'(DQ_O), 64'hFF803FE00);

        // Write 7 immediately followed by read 7
        DQ_I = rnd36(); cmd_wr(7, '0);
        cmd_rd(7);
        DQ_I = 36'h0A5A5A5A5; cmd_nop();
        DQ_I = rnd36(); cmd_nop();
        chk("raw_fwd_data", 64'(DQ_O), 64'h0A5A5A5A5);
        chk("raw_fwd_oe", 64'(DQ_OE), 64'd1);

        // Reset one edge after a write: write discarded
        DQ_I = rnd36(); cmd_wr(9, '0);
        cmd_nop();
        DQ_I = dval(9); cmd_nop();
        DQ_I = '0; cmd_wr(9, '0);
        RST = 1'b1; cyc();
        chk("rst_mid_oe", 64'(DQ_OE), 64'd0);
        chk("rst_mid_dq", 64'(DQ_O), 64'd0);
        RST = 1'b0;
        cmd_nop(); cmd_nop();
        DQ_I = rnd36(); cmd_rd(9);
        cmd_nop(); cmd_nop();
        chk("rst_drop_write", 64'(DQ_O), 64'(dval(9)));

        // Flow-through, linear: write burst 0..3 then read burst from 2
        do_reset(1'b0, 1'b0);
        cmd_wr(0, '0);
        for (int i = 0; i < 4; i++) begin
            DQ_I = dval(i);
            if (i < 3) cmd_adv(); else cmd_nop();
        end
        DQ_I = rnd36();
        cmd_rd(2);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cmd_adv(); else cmd_nop();
            chk("flow_lin_data", 64'(DQ_O), 64'(dval(ord_lin[i])));
            chk("flow_lin_oe", 64'(DQ_OE), 64'd1);
        end

        // Clock enable held off mid-burst
        cmd_rd(0);
        cmd_adv();
        chk("cke_beat0", 64'(DQ_O), 64'(dval(0)));
        cmd_adv();
        chk("cke_beat1", 64'(DQ_O), 64'(dval(1)));
        for (int i = 0; i < 3; i++) begin
            cmd_hold();
            chk("cke_freeze_dq", 64'(DQ_O), 64'(dval(1)));
            chk("cke_freeze_oe", 64'(DQ_OE), 64'd1);
        end
        cmd_adv();
        chk("cke_beat2", 64'(DQ_O), 64'(dval(2)));
        cmd_nop();
        chk("cke_beat3", 64'(DQ_O), 64'(dval(3)));

        // Flow-through, interleaved bursts from 2 and from 1
        do_reset(1'b0, 1'b1);
        cmd_rd(2);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cmd_adv(); else cmd_nop();
            chk("ilv2_data", 64'(DQ_O), 64'(dval(ord_i2[i])));
        end
        cmd_rd(1);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cmd_adv(); else cmd_nop();
            chk("ilv1_data", 64'(DQ_O), 64'(dval(ord_i1[i])));
        end

        // Randomized traffic over words 0..15, mode chosen at each reset
        for (int blk = 0; blk < 4; blk++) begin
            do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 150; i++) begin
                A    = AW'($urandom_range(0, 15));
                nW   = 1'($urandom_range(0, 1));
                nB   = NL'($urandom());
                pADV = ($urandom_range(0, 9) < 4);
                nE1  = ($urandom_range(0, 9) == 0);
                E2   = ($urandom_range(0, 15) != 0);
                nCKE = ($urandom_range(0, 9) == 0);
                nG   = ($urandom_range(0, 7) == 0);
                ZZ   = ($urandom_range(0, 19) == 0);
                DQ_I = rnd36();
                cyc();
            end
            E2 = 1'b1; nCKE = 1'b0; nG = 1'b0; ZZ = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
